teclado_acumulador: RTL and testbench
=====================================

Name: teclado_acumulador

Overview:
- Upstream input stage of the calculator control FSM.
- Takes raw keypad scanner output, synchronises and debounces it, and classifies each key press as a digit or an operator.
- Accumulates decimal digits into a 32-bit binary operand and emits one-cycle rec_num / rec_op strobes to the FSM.
- The FSM's guardeNum level clears the operand accumulator. The processor reads number / op_code when the FSM asserts its store strobes.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive synchronised-stable cycles required to accept a press or a release (>=1).
MAX_DIGITS, 9, maximum accepted digits per operand; 9 guarantees the value fits in 32 bits.

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
key_valid  input  1  asynchronous from scanner; high while a key is held
key_code  input  5  key identity, meaningful while key_valid=1: 0-9 digit, 10 '+', 11 '-', 12 '*', 13 '=', 14-31 ignored
clr_num  input  1  level; driven by FSM guardeNum; clears the accumulator
rec_num  output  1  one-cycle pulse per accepted digit key
rec_op  output  1  one-cycle pulse per operator key (codes 10-13)
number  output  32  accumulated unsigned operand
op_code  output  2  last operator: '+'=0, '-'=1, '*'=2, '='=3
digit_count  output  4  digits accepted into the current operand
ovf  output  1  sticky; a digit beyond MAX_DIGITS was rejected

Behaviour:
- Reset (rst_n=0, asynchronous): all of the following go to 0 immediately — rec_num, rec_op, number, op_code, digit_count, ovf, sync flops, debounce counter. State goes to IDLE.
- Reset mid-press: the press is discarded. After release of reset, a still-held key must first pass through IDLE -> DB_PRESS again.
- Synchroniser: key_valid passes through 2 flops to give key_s. key_code is captured into a register on the DB_PRESS -> EMIT transition. The scanner holds key_code stable while key_valid=1.
- Press-detect FSM:
  - IDLE: key_s=1 -> DB_PRESS, counter=1.
  - DB_PRESS: key_s=0 -> IDLE (glitch rejected). If key_s=1 and counter==DEBOUNCE_CYCLES -> EMIT, capture key_code. Otherwise counter++.
  - EMIT: one cycle. Pulse outputs are registered here; next state is HELD.
  - HELD: key_s=0 -> DB_RELEASE, counter=1.
  - DB_RELEASE: key_s=1 -> HELD (bounce). If key_s=0 and counter==DEBOUNCE_CYCLES -> IDLE. Otherwise counter++.
- Latency:
  - key_valid high sampled at edge 1 -> rec_num/rec_op high during the cycle after edge DEBOUNCE_CYCLES+3, for exactly 1 cycle.
  - One pulse per press, regardless of hold length.
- Digit accept (code 0-9) in EMIT:
  - If digit_count<MAX_DIGITS: number <= number*10 + code, digit_count++, both registered in the same edge that raises rec_num. Compute in 36 bits and truncate to 32.
  - Else: number and digit_count unchanged, ovf <= 1, rec_num still pulses.
  - Leading zeros count as digits.
- Operator accept (code 10-13) in EMIT: op_code <= code-10, rec_op pulses. number and digit_count are unchanged.
- Codes 14-31: FSM sequence runs normally, no pulse, no register change.
- clr_num=1 at an edge: number, digit_count and ovf <= 0.
  - If a digit EMIT coincides, clear wins and the digit is dropped, but rec_num still pulses.
  - clr_num does not affect op_code or the FSM.
  - A held-high clr_num keeps number at 0.
- rec_num and rec_op are never high together. They are never high two consecutive cycles.

Test Plan:
- Reset with DEBOUNCE_CYCLES=4: rst_n low -> all outputs 0. Press code 7, held 20 cycles -> single rec_num pulse 7 edges after key_valid rise, number=7, digit_count=1.
- Digits 1,2,3 then code 11 -> number=123; rec_op pulse with op_code=1; number stays 123.
- key_valid high 2 cycles, low, high 2 cycles (bounce) then stable -> exactly one pulse. Release bounce of 1-cycle low blips -> no extra pulse.
- Ten presses of digit 9 -> number=999999999, digit_count=9; tenth press gives rec_num pulse, number unchanged, ovf=1. Then clr_num=1 -> number=0, digit_count=0, ovf=0.
- clr_num held high while digit 5 emits -> rec_num pulses, number=0. Release clr_num, press 5 -> number=5.
- Code 20 pressed -> no rec_num/rec_op. Assert rst_n=0 during DB_PRESS of a digit -> outputs 0, no pulse after reset while key is still held until the full debounce completes.

Source files
------------

// File: rtl/teclado_acumulador.sv
// teclado_acumulador: keypad synchroniser, debouncer, key classifier and decimal operand accumulator
module teclado_acumulador #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MAX_DIGITS = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  input  logic [4:0]  key_code,
  input  logic        clr_num,
  output logic        rec_num,
  output logic        rec_op,
  output logic [31:0] number,
  output logic [1:0]  op_code,
  output logic [3:0]  digit_count,
  output logic        ovf
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [3:0] DIG_MAX = 4'(MAX_DIGITS);
  typedef enum logic [2:0] {IDLE, DB_PRESS, EMIT, HELD, DB_RELEASE} state_t;
  state_t state_q, state_d;
  logic [1:0] sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic rec_num_q, rec_num_d, rec_op_q, rec_op_d, ovf_q, ovf_d;
  logic [31:0] number_q, number_d;
  logic [1:0] op_code_q, op_code_d;
  logic [3:0] digit_count_q, digit_count_d;
  logic key_s, emit, is_digit, is_op, room;
  assign key_s = sync_q[1];
  // The key is captured on the very edge that enters EMIT, so pulses and accumulator update share that edge
  assign emit = state_q == DB_PRESS && key_s && cnt_q == DB_MAX;
  assign is_digit = key_code < 5'd10;
  assign is_op = !is_digit && key_code < 5'd14;
  assign room = digit_count_q < DIG_MAX;
  assign rec_num = rec_num_q;
  assign rec_op = rec_op_q;
  assign number = number_q;
  assign op_code = op_code_q;
  assign digit_count = digit_count_q;
  assign ovf = ovf_q;
  // Press/release debounce: a level must be seen DEBOUNCE_CYCLES+1 consecutive samples to be accepted
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (key_s) begin
        state_d = DB_PRESS;
        cnt_d = CW'(1);
      end
      DB_PRESS: if (!key_s) state_d = IDLE;
        else if (cnt_q == DB_MAX) state_d = EMIT;
        else cnt_d = cnt_q + CW'(1);
      EMIT: state_d = HELD;
      HELD: if (!key_s) begin
        state_d = DB_RELEASE;
        cnt_d = CW'(1);
      end
      DB_RELEASE: if (key_s) state_d = HELD;
        else if (cnt_q == DB_MAX) state_d = IDLE;
        else cnt_d = cnt_q + CW'(1);
      default: state_d = IDLE;
    endcase
  end
  // Key classification and operand accumulation; clear beats a coinciding digit but the pulse survives
  always_comb begin
    rec_num_d = emit && is_digit;
    rec_op_d = emit && is_op;
    number_d = clr_num ? '0 : (rec_num_d && room) ? 32'({4'd0, number_q} * 36'd10 + 36'(key_code)) : number_q;
    digit_count_d = clr_num ? '0 : (rec_num_d && room) ? digit_count_q + 4'd1 : digit_count_q;
    ovf_d = !clr_num && (ovf_q || (rec_num_d && !room));
    op_code_d = rec_op_d ? key_code[1:0] - 2'd2 : op_code_q;
  end
  // State, synchroniser and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sync_q <= '0;
      cnt_q <= '0;
      rec_num_q <= 1'b0;
      rec_op_q <= 1'b0;
      number_q <= '0;
      op_code_q <= '0;
      digit_count_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q <= {sync_q[0], key_valid};
      cnt_q <= cnt_d;
      rec_num_q <= rec_num_d;
      rec_op_q <= rec_op_d;
      number_q <= number_d;
      op_code_q <= op_code_d;
      digit_count_q <= digit_count_d;
      ovf_q <= ovf_d;
    end
  end
endmodule

// File: tb/tb_teclado_acumulador.sv
// tb_teclado_acumulador: scoreboard bench with a behavioural calculator-keypad model
module tb_teclado_acumulador;
  localparam int DB = 4;
  localparam int MAXD = 9;
  logic clk = 0, rst_n = 0, key_valid = 0, clr_num = 0;
  logic [4:0] key_code = '0;
  logic rec_num, rec_op, ovf;
  logic [31:0] number;
  logic [1:0] op_code;
  logic [3:0] digit_count;
  teclado_acumulador #(.DEBOUNCE_CYCLES(DB), .MAX_DIGITS(MAXD)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code), .clr_num(clr_num),
    .rec_num(rec_num), .rec_op(rec_op), .number(number), .op_code(op_code),
    .digit_count(digit_count), .ovf(ovf)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {int kind; longint num; int dc; int ovf; int op; int cyc;} exp_t;
  exp_t q[$];
  exp_t mon_e;
  int tests = 0, fails = 0;
  longint m_num = 0;
  int m_cnt = 0, m_ovf = 0, m_op = 0;
  bit prev = 0;
  task automatic chk(input string name, input longint act, input longint req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask
  // Reference model: a calculator keypad accepting up to MAXD decimal digits per operand
  task automatic apply(input int code, input bit clr, input int when);
    exp_t e;
    if (code > 13) return;
    if (code <= 9) begin
      e.kind = 1;
      if (clr) begin
        m_num = 0;
        m_cnt = 0;
        m_ovf = 0;
      end else if (m_cnt < MAXD) begin
        m_num = m_num * 10 + code;
        m_cnt++;
      end else m_ovf = 1;
    end else begin
      e.kind = 2;
      m_op = code - 10;
    end
    e.num = m_num;
    e.dc = m_cnt;
    e.ovf = m_ovf;
    e.op = m_op;
    e.cyc = when;
    q.push_back(e);
  endtask
  task automatic state_chk(input string tag);
    chk({tag, "_number"}, number, m_num);
    chk({tag, "_digit_count"}, digit_count, m_cnt);
    chk({tag, "_ovf"}, ovf, m_ovf);
    chk({tag, "_op_code"}, op_code, m_op);
  endtask
  task automatic rst_chk(input string tag);
    chk({tag, "_rec_num"}, rec_num, 0);
    chk({tag, "_rec_op"}, rec_op, 0);
    chk({tag, "_number"}, number, 0);
    chk({tag, "_op_code"}, op_code, 0);
    chk({tag, "_digit_count"}, digit_count, 0);
    chk({tag, "_ovf"}, ovf, 0);
  endtask
  task automatic clr_pulse();
    clr_num = 1;
    @(negedge clk);
    clr_num = 0;
    m_num = 0;
    m_cnt = 0;
    m_ovf = 0;
  endtask
  // One key press: optional press bounce, stable hold, optional release bounce, then a settled idle gap
  task automatic press(input int code, input int hold, input bit pb, input bit rb, input bit clr);
    key_code = 5'(code);
    if (pb) repeat (2) begin
      key_valid = 1;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      key_valid = 0;
      repeat ($urandom_range(1, 2)) @(negedge clk);
    end
    key_valid = 1;
    apply(code, clr, cyc + DB + 3);
    repeat (hold) @(negedge clk);
    if (rb) repeat (2) begin
      key_valid = 0;
      @(negedge clk);
      key_valid = 1;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    key_valid = 0;
    repeat (DB + 6) @(negedge clk);
    state_chk($sformatf("after_key%0d", code));
  endtask
  // Monitor: every strobe must match the oldest expected key event, at the expected cycle
  always @(negedge clk) begin
    if (!rst_n) prev <= 0;
    else begin
      if (rec_num || rec_op) begin
        chk("pulse_gap", prev, 0);
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_pulse rec_num=%0b rec_op=%0b required=no pulse (cycle %0d)", rec_num, rec_op, cyc);
        end else begin
          mon_e = q.pop_front();
          chk("pulse_kind", {rec_num, rec_op}, mon_e.kind == 1 ? 2 : 1);
          chk("pulse_cycle", cyc, mon_e.cyc);
          chk("pulse_number", number, mon_e.num);
          chk("pulse_digit_count", digit_count, mon_e.dc);
          chk("pulse_ovf", ovf, mon_e.ovf);
          chk("pulse_op_code", op_code, mon_e.op);
        end
      end
      prev <= rec_num || rec_op;
    end
  end
  initial begin
    repeat (3) @(negedge clk);
    rst_chk("reset");
    rst_n = 1;
    @(negedge clk);
    press(7, 20, 0, 0, 0);
    clr_pulse();
    press(1, 12, 0, 0, 0);
    press(2, 12, 0, 0, 0);
    press(3, 12, 0, 0, 0);
    press(11, 12, 0, 0, 0);
    press(4, 15, 1, 1, 0);
    clr_pulse();
    for (int i = 0; i < 10; i++) press(9, 10, 0, 0, 0);
    clr_pulse();
    state_chk("after_clear");
    clr_num = 1;
    @(negedge clk);
    press(5, 12, 0, 0, 1);
    clr_num = 0;
    @(negedge clk);
    press(5, 12, 0, 0, 0);
    press(20, 12, 0, 0, 0);
    key_code = 5'd3;
    key_valid = 1;
    repeat (4) @(negedge clk);
    rst_n = 0;
    #1;
    rst_chk("mid_press_reset");
    chk("mid_press_queue", q.size(), 0);
    m_num = 0;
    m_cnt = 0;
    m_ovf = 0;
    m_op = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    apply(3, 0, cyc + DB + 3);
    repeat (15) @(negedge clk);
    key_valid = 0;
    repeat (DB + 6) @(negedge clk);
    state_chk("after_reset_press");
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) clr_pulse();
      press($urandom_range(0, 15), $urandom_range(10, 25), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    end
    repeat (20) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
